// File: rtl/alu_issue_queue.sv
// ----------------------------------------------------------------------------
// alu_issue_queue
//   ALU reservation station. Holds up to RS_DEPTH decoded ALU ops with their
//   operands, snoops NUM_CDB result-broadcast ports to wake waiting operands,
//   and issues the oldest fully-ready op to one ALU through a registered
//   valid/ready output stage.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush               squash every entry and the output register
//   alloc_*             allocation side from decode/rename (valid/ready)
//   cdb_valid/tag/value common data bus, port p packed at [p*W +: W]
//   issue_*             registered output to the ALU (valid/ready)
//   occupancy           number of valid entries (output register excluded)
// ----------------------------------------------------------------------------
module alu_issue_queue #(
  parameter int RS_DEPTH = 8,
  parameter int NUM_CDB  = 4,
  parameter int TAG_W    = 3,
  parameter int XLEN     = 32,
  parameter int OP_W     = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        alloc_valid,
  output logic                        alloc_ready,
  input  logic [OP_W-1:0]             alloc_op,
  input  logic [TAG_W-1:0]            alloc_rob_tag,
  input  logic [XLEN-1:0]             alloc_vj,
  input  logic [XLEN-1:0]             alloc_vk,
  input  logic                        alloc_rj,
  input  logic                        alloc_rk,
  input  logic [TAG_W-1:0]            alloc_qj,
  input  logic [TAG_W-1:0]            alloc_qk,
  input  logic [NUM_CDB-1:0]          cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]     cdb_value,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic [OP_W-1:0]             issue_op,
  output logic [XLEN-1:0]             issue_a,
  output logic [XLEN-1:0]             issue_b,
  output logic [TAG_W-1:0]            issue_rob_tag,
  output logic [$clog2(RS_DEPTH):0]   occupancy
);
  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = $clog2(RS_DEPTH) + 1;

  // Control state (reset) and entry payload (no reset, qualified by valid_q).
  logic [RS_DEPTH-1:0] valid_q, valid_d;
  logic [RS_DEPTH-1:0] age_q [RS_DEPTH];  // age_q[i][j]=1: entry j is older than entry i
  logic [RS_DEPTH-1:0] age_d [RS_DEPTH];
  logic [RS_DEPTH-1:0] rj_q, rj_d, rk_q, rk_d;
  logic [OP_W-1:0]     op_q      [RS_DEPTH], op_d      [RS_DEPTH];
  logic [TAG_W-1:0]    rob_tag_q [RS_DEPTH], rob_tag_d [RS_DEPTH];
  logic [TAG_W-1:0]    qj_q      [RS_DEPTH], qj_d      [RS_DEPTH];
  logic [TAG_W-1:0]    qk_q      [RS_DEPTH], qk_d      [RS_DEPTH];
  logic [XLEN-1:0]     vj_q      [RS_DEPTH], vj_d      [RS_DEPTH];
  logic [XLEN-1:0]     vk_q      [RS_DEPTH], vk_d      [RS_DEPTH];

  logic                issue_valid_q, issue_valid_d;
  logic [OP_W-1:0]     issue_op_q, issue_op_d;
  logic [XLEN-1:0]     issue_a_q, issue_a_d, issue_b_q, issue_b_d;
  logic [TAG_W-1:0]    issue_rob_tag_q, issue_rob_tag_d;

  // Returns {hit, value}; the loop runs downward so the lowest matching port wins.
  function automatic logic [XLEN:0] cdb_lookup(
    input logic [TAG_W-1:0]         tag,
    input logic [NUM_CDB-1:0]       vld,
    input logic [NUM_CDB*TAG_W-1:0] tags,
    input logic [NUM_CDB*XLEN-1:0]  vals
  );
    logic [XLEN:0] r;
    r = '0;
    for (int p = NUM_CDB - 1; p >= 0; p--)
      if (vld[p] && tags[p*TAG_W +: TAG_W] == tag) r = {1'b1, vals[p*XLEN +: XLEN]};
    return r;
  endfunction

  logic [RS_DEPTH-1:0] ready_vec, oldest_vec;
  logic [XLEN:0]       wake_j [RS_DEPTH];
  logic [XLEN:0]       wake_k [RS_DEPTH];
  logic [XLEN:0]       byp_j, byp_k;
  logic [IDX_W-1:0]    sel_idx, free_idx;
  logic                any_ready, do_alloc;

  for (genvar gi = 0; gi < RS_DEPTH; gi++) begin : g_entry
    // Selection looks only at registered ready bits; a same-cycle CDB hit
    // becomes selectable one cycle later.
    assign ready_vec[gi]  = valid_q[gi] & rj_q[gi] & rk_q[gi];
    assign oldest_vec[gi] = ready_vec[gi] & ~|(ready_vec & age_q[gi]);
    assign wake_j[gi]     = cdb_lookup(qj_q[gi], cdb_valid, cdb_tag, cdb_value);
    assign wake_k[gi]     = cdb_lookup(qk_q[gi], cdb_valid, cdb_tag, cdb_value);
  end

  assign byp_j     = cdb_lookup(alloc_qj, cdb_valid, cdb_tag, cdb_value);
  assign byp_k     = cdb_lookup(alloc_qk, cdb_valid, cdb_tag, cdb_value);
  assign any_ready = |ready_vec;

  always_comb begin
    sel_idx  = '0;
    free_idx = '0;
    occupancy = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (oldest_vec[i]) sel_idx = IDX_W'(i);
      occupancy = occupancy + CNT_W'(valid_q[i]);
    end
    for (int i = RS_DEPTH - 1; i >= 0; i--)
      if (!valid_q[i]) free_idx = IDX_W'(i);
  end

  // Free slot is chosen from registered valid bits, so a slot vacated by an
  // issue this cycle cannot be refilled until the next one.
  assign alloc_ready = (occupancy < CNT_W'(RS_DEPTH));
  assign do_alloc    = alloc_valid & alloc_ready;

  always_comb begin
    valid_d = valid_q;  age_d = age_q;
    rj_d = rj_q;  rk_d = rk_q;  op_d = op_q;  rob_tag_d = rob_tag_q;
    qj_d = qj_q;  qk_d = qk_q;  vj_d = vj_q;  vk_d = vk_q;
    issue_valid_d = issue_valid_q;  issue_op_d = issue_op_q;
    issue_a_d = issue_a_q;  issue_b_d = issue_b_q;  issue_rob_tag_d = issue_rob_tag_q;

    // Operand wakeup
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (valid_q[i] && !rj_q[i] && wake_j[i][XLEN]) begin
        rj_d[i] = 1'b1;
        vj_d[i] = wake_j[i][XLEN-1:0];
      end
      if (valid_q[i] && !rk_q[i] && wake_k[i][XLEN]) begin
        rk_d[i] = 1'b1;
        vk_d[i] = wake_k[i][XLEN-1:0];
      end
    end

    // Output stage: refill when empty or being drained; drop valid if nothing is ready
    if (!issue_valid_q || issue_ready) begin
      issue_valid_d = any_ready;
      if (any_ready) begin
        issue_op_d       = op_q[sel_idx];
        issue_a_d        = vj_q[sel_idx];
        issue_b_d        = vk_q[sel_idx];
        issue_rob_tag_d  = rob_tag_q[sel_idx];
        valid_d[sel_idx] = 1'b0;
        age_d[sel_idx]   = '0;
        for (int j = 0; j < RS_DEPTH; j++) age_d[j][sel_idx] = 1'b0;
      end
    end

    // Allocation: new entry is younger than everything still valid after issue
    if (do_alloc) begin
      age_d[free_idx] = valid_d;
      for (int j = 0; j < RS_DEPTH; j++) age_d[j][free_idx] = 1'b0;
      valid_d[free_idx]   = 1'b1;
      op_d[free_idx]      = alloc_op;
      rob_tag_d[free_idx] = alloc_rob_tag;
      qj_d[free_idx]      = alloc_qj;
      qk_d[free_idx]      = alloc_qk;
      rj_d[free_idx]      = alloc_rj | byp_j[XLEN];
      rk_d[free_idx]      = alloc_rk | byp_k[XLEN];
      vj_d[free_idx]      = (!alloc_rj && byp_j[XLEN]) ? byp_j[XLEN-1:0] : alloc_vj;
      vk_d[free_idx]      = (!alloc_rk && byp_k[XLEN]) ? byp_k[XLEN-1:0] : alloc_vk;
    end

    // Flush overrides everything above
    if (flush) begin
      valid_d = '0;
      for (int i = 0; i < RS_DEPTH; i++) age_d[i] = '0;
      issue_valid_d   = 1'b0;
      issue_op_d      = '0;
      issue_a_d       = '0;
      issue_b_d       = '0;
      issue_rob_tag_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < RS_DEPTH; i++) age_q[i] <= '0;
      issue_valid_q   <= 1'b0;
      issue_op_q      <= '0;
      issue_a_q       <= '0;
      issue_b_q       <= '0;
      issue_rob_tag_q <= '0;
    end else begin
      valid_q         <= valid_d;
      age_q           <= age_d;
      issue_valid_q   <= issue_valid_d;
      issue_op_q      <= issue_op_d;
      issue_a_q       <= issue_a_d;
      issue_b_q       <= issue_b_d;
      issue_rob_tag_q <= issue_rob_tag_d;
    end
  end

  always_ff @(posedge clk) begin
    rj_q <= rj_d;  rk_q <= rk_d;  op_q <= op_d;  rob_tag_q <= rob_tag_d;
    qj_q <= qj_d;  qk_q <= qk_d;  vj_q <= vj_d;  vk_q <= vk_d;
  end

  assign issue_valid   = issue_valid_q;
  assign issue_op      = issue_op_q;
  assign issue_a       = issue_a_q;
  assign issue_b       = issue_b_q;
  assign issue_rob_tag = issue_rob_tag_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// ----------------------------------------------------------------------------
// tb_alu_issue_queue
//   Self-checking bench for alu_issue_queue. A reference model keeps the
//   waiting ops in a queue ordered by allocation age plus one output slot and
//   is stepped every cycle; the DUT is compared against it after each edge.
//   A table of single-op vectors, hand-written multi-cycle sequences and a
//   randomized phase drive the design.
// ----------------------------------------------------------------------------
module tb_alu_issue_queue;
  localparam int DEPTH = 8;
  localparam int NC    = 4;
  localparam int TW    = 3;
  localparam int XL    = 32;
  localparam int OW    = 3;
  localparam int CTW   = NC * TW;
  localparam int CVW   = NC * XL;

  logic            clk = 1'b0;
  logic            rst, flush;
  logic            alloc_valid, alloc_ready;
  logic [OW-1:0]   alloc_op;
  logic [TW-1:0]   alloc_rob_tag, alloc_qj, alloc_qk;
  logic [XL-1:0]   alloc_vj, alloc_vk;
  logic            alloc_rj, alloc_rk;
  logic [NC-1:0]   cdb_valid;
  logic [CTW-1:0]  cdb_tag;
  logic [CVW-1:0]  cdb_value;
  logic            issue_valid, issue_ready;
  logic [OW-1:0]   issue_op;
  logic [XL-1:0]   issue_a, issue_b;
  logic [TW-1:0]   issue_rob_tag;
  logic [$clog2(DEPTH):0] occupancy;

  always #5 clk = ~clk;

  alu_issue_queue #(.RS_DEPTH(DEPTH), .NUM_CDB(NC), .TAG_W(TW), .XLEN(XL), .OP_W(OW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_op(alloc_op),
    .alloc_rob_tag(alloc_rob_tag), .alloc_vj(alloc_vj), .alloc_vk(alloc_vk),
    .alloc_rj(alloc_rj), .alloc_rk(alloc_rk), .alloc_qj(alloc_qj), .alloc_qk(alloc_qk),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_a(issue_a), .issue_b(issue_b), .issue_rob_tag(issue_rob_tag),
    .occupancy(occupancy)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [OW-1:0] op;
    logic [TW-1:0] tag;
    logic [XL-1:0] vj, vk;
    logic          rj, rk;
    logic [TW-1:0] qj, qk;
  } ent_t;

  ent_t mq[$];       // waiting ops, index 0 = oldest
  bit   m_ov;        // output slot occupied
  ent_t m_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic [TW-1:0] dut_log[$];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // First (lowest-numbered) valid port carrying the tag supplies the value.
  function automatic bit cdb_hit(input logic [TW-1:0] t, output logic [XL-1:0] v);
    v = '0;
    for (int p = 0; p < NC; p++)
      if (cdb_valid[p] && cdb_tag[p*TW +: TW] == t) begin
        v = cdb_value[p*XL +: XL];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  task automatic model_step();
    int sel;
    int pre_size;
    ent_t e;
    logic [XL-1:0] v;
    if (rst || flush) begin
      mq.delete();
      m_ov  = 1'b0;
      m_out = '{op: '0, tag: '0, vj: '0, vk: '0, rj: 1'b0, rk: 1'b0, qj: '0, qk: '0};
      return;
    end
    pre_size = mq.size();
    sel = -1;
    if (!m_ov || issue_ready) begin
      for (int i = 0; i < mq.size(); i++)
        if (mq[i].rj && mq[i].rk) begin sel = i; break; end
      m_ov = (sel >= 0);
      if (sel >= 0) m_out = mq[sel];
    end
    for (int i = 0; i < mq.size(); i++) begin
      e = mq[i];
      if (!e.rj && cdb_hit(e.qj, v)) begin e.rj = 1'b1; e.vj = v; end
      if (!e.rk && cdb_hit(e.qk, v)) begin e.rk = 1'b1; e.vk = v; end
      mq[i] = e;
    end
    if (sel >= 0) mq.delete(sel);
    if (alloc_valid && pre_size < DEPTH) begin
      e = '{op: alloc_op, tag: alloc_rob_tag, vj: alloc_vj, vk: alloc_vk,
            rj: alloc_rj, rk: alloc_rk, qj: alloc_qj, qk: alloc_qk};
      if (!e.rj && cdb_hit(e.qj, v)) begin e.rj = 1'b1; e.vj = v; end
      if (!e.rk && cdb_hit(e.qk, v)) begin e.rk = 1'b1; e.vk = v; end
      mq.push_back(e);
    end
  endtask

  task automatic check_outputs();
    cmp("issue_valid", issue_valid, m_ov);
    if (m_ov) begin
      cmp("issue_op", issue_op, m_out.op);
      cmp("issue_a", issue_a, m_out.vj);
      cmp("issue_b", issue_b, m_out.vk);
      cmp("issue_rob_tag", issue_rob_tag, m_out.tag);
    end
    cmp("occupancy", occupancy, mq.size());
    cmp("alloc_ready", alloc_ready, mq.size() < DEPTH);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic set_idle();
    flush = 1'b0; alloc_valid = 1'b0; alloc_op = '0; alloc_rob_tag = '0;
    alloc_vj = '0; alloc_vk = '0; alloc_rj = 1'b0; alloc_rk = 1'b0;
    alloc_qj = '0; alloc_qk = '0; cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
  endtask

  task automatic drive_alloc(input logic [OW-1:0] op, input logic [TW-1:0] tag,
                             input logic [XL-1:0] vj, input logic [XL-1:0] vk,
                             input logic rj, input logic rk,
                             input logic [TW-1:0] qj, input logic [TW-1:0] qk);
    alloc_valid = 1'b1; alloc_op = op; alloc_rob_tag = tag; alloc_vj = vj; alloc_vk = vk;
    alloc_rj = rj; alloc_rk = rk; alloc_qj = qj; alloc_qk = qk;
  endtask

  always @(posedge clk) begin
    if (!rst && !flush && issue_valid && issue_ready) begin
      dut_log.push_back(issue_rob_tag);
      $display("[TB] issue tag=%0d op=%0d a=0x%08h b=0x%08h", issue_rob_tag, issue_op, issue_a, issue_b);
    end
  end

  // ---------------- single-op vector table ----------------
  typedef struct {
    logic [OW-1:0]  op;
    logic [TW-1:0]  tag;
    logic [XL-1:0]  vj, vk;
    logic           rj, rk;
    logic [TW-1:0]  qj, qk;
    logic [NC-1:0]  cv;
    logic [CTW-1:0] ct;
    logic [CVW-1:0] cval;
    logic           exp_issue;
    logic [XL-1:0]  exp_a, exp_b;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // both ready at allocation (ADD 5,7 -> tag 2)
    vecs[0] = '{op: 3'd0, tag: 3'd2, vj: 32'd5, vk: 32'd7, rj: 1'b1, rk: 1'b1, qj: 3'd0, qk: 3'd0,
                cv: 4'b0000, ct: '0, cval: '0, exp_issue: 1'b1, exp_a: 32'd5, exp_b: 32'd7};
    // k bypassed from CDB port 1 at allocation
    vecs[1] = '{op: 3'd1, tag: 3'd3, vj: 32'd1, vk: 32'd0, rj: 1'b1, rk: 1'b0, qj: 3'd0, qk: 3'd4,
                cv: 4'b0010, ct: {3'd0, 3'd0, 3'd4, 3'd0}, cval: {32'h0, 32'h0, 32'hAB, 32'h0},
                exp_issue: 1'b1, exp_a: 32'd1, exp_b: 32'hAB};
    // both bypassed, tag 0 is a real tag; invalid ports also carry tag 0
    vecs[2] = '{op: 3'd2, tag: 3'd0, vj: 32'd0, vk: 32'd0, rj: 1'b0, rk: 1'b0, qj: 3'd0, qk: 3'd6,
                cv: 4'b1001, ct: {3'd6, 3'd0, 3'd0, 3'd0}, cval: {32'h66, 32'hEE, 32'hDD, 32'h11},
                exp_issue: 1'b1, exp_a: 32'h11, exp_b: 32'h66};
    // two ports carry the tag: port 1 wins over port 2
    vecs[3] = '{op: 3'd3, tag: 3'd7, vj: 32'd0, vk: 32'd9, rj: 1'b0, rk: 1'b1, qj: 3'd5, qk: 3'd0,
                cv: 4'b0110, ct: {3'd0, 3'd5, 3'd5, 3'd0}, cval: {32'h0, 32'h33, 32'h22, 32'h0},
                exp_issue: 1'b1, exp_a: 32'h22, exp_b: 32'd9};
    // operand already ready keeps its own value despite a matching broadcast
    vecs[4] = '{op: 3'd4, tag: 3'd1, vj: 32'h77, vk: 32'd0, rj: 1'b1, rk: 1'b1, qj: 3'd1, qk: 3'd0,
                cv: 4'b0001, ct: {3'd0, 3'd0, 3'd0, 3'd1}, cval: {32'h0, 32'h0, 32'h0, 32'h99},
                exp_issue: 1'b1, exp_a: 32'h77, exp_b: 32'd0};
    // matching tag on an invalid port does not wake the operand
    vecs[5] = '{op: 3'd5, tag: 3'd6, vj: 32'd0, vk: 32'd3, rj: 1'b0, rk: 1'b1, qj: 3'd2, qk: 3'd0,
                cv: 4'b0000, ct: {3'd0, 3'd0, 3'd0, 3'd2}, cval: {32'h0, 32'h0, 32'h0, 32'h55},
                exp_issue: 1'b0, exp_a: 32'd0, exp_b: 32'd0};
  end

  initial begin
    set_idle();
    issue_ready = 1'b0;
    rst = 1'b1;
    #2;
    tick(); tick();
    rst = 1'b0;
    cmp("rst_issue_valid", issue_valid, 1'b0);
    cmp("rst_occupancy", occupancy, 0);
    cmp("rst_alloc_ready", alloc_ready, 1'b1);
    cmp("rst_issue_a", issue_a, 0);
    cmp("rst_issue_b", issue_b, 0);
    cmp("rst_issue_tag", issue_rob_tag, 0);
    cmp("rst_issue_op", issue_op, 0);

    // ---- table vectors ----
    for (int i = 0; i < 6; i++) begin
      set_idle(); issue_ready = 1'b1; flush = 1'b1;
      tick();
      flush = 1'b0;
      drive_alloc(vecs[i].op, vecs[i].tag, vecs[i].vj, vecs[i].vk,
                  vecs[i].rj, vecs[i].rk, vecs[i].qj, vecs[i].qk);
      cdb_valid = vecs[i].cv; cdb_tag = vecs[i].ct; cdb_value = vecs[i].cval;
      tick();
      cmp($sformatf("vec%0d_not_yet", i), issue_valid, 1'b0);
      set_idle();
      tick();
      cmp($sformatf("vec%0d_valid", i), issue_valid, vecs[i].exp_issue);
      if (vecs[i].exp_issue) begin
        cmp($sformatf("vec%0d_a", i), issue_a, vecs[i].exp_a);
        cmp($sformatf("vec%0d_b", i), issue_b, vecs[i].exp_b);
        cmp($sformatf("vec%0d_tag", i), issue_rob_tag, vecs[i].tag);
        cmp($sformatf("vec%0d_op", i), issue_op, vecs[i].op);
      end
      $display("[TB] vector %0d applied: tag=%0d issue_valid=%0b a=0x%0h b=0x%0h",
               i, vecs[i].tag, issue_valid, issue_a, issue_b);
    end

    // ---- younger ready op overtakes an older waiting op ----
    set_idle(); issue_ready = 1'b1; flush = 1'b1; tick();
    flush = 1'b0;
    drive_alloc(3'd1, 3'd1, 32'd0, 32'd2, 1'b0, 1'b1, 3'd3, 3'd0); tick();
    drive_alloc(3'd2, 3'd5, 32'd8, 32'd9, 1'b1, 1'b1, 3'd0, 3'd0); tick();
    cmp("ooo_none_yet", issue_valid, 1'b0);
    set_idle(); cdb_valid = 4'b0001; cdb_tag = {3'd0, 3'd0, 3'd0, 3'd3}; cdb_value = {96'h0, 32'h10};
    tick();
    cmp("ooo_first_valid", issue_valid, 1'b1);
    cmp("ooo_first_tag", issue_rob_tag, 5);
    set_idle(); tick();
    cmp("ooo_second_tag", issue_rob_tag, 1);
    cmp("ooo_second_a", issue_a, 32'h10);
    cmp("ooo_second_b", issue_b, 32'd2);
    $display("[TB] out-of-order wakeup sequence done");

    // ---- fill to full, blocked alloc, one slot frees ----
    set_idle(); issue_ready = 1'b0; flush = 1'b1; tick();
    flush = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_alloc(3'd0, TW'(i), 32'd0, 32'd1, 1'b0, 1'b1, 3'd7, 3'd0);
      tick();
    end
    drive_alloc(3'd6, 3'd1, 32'd4, 32'd4, 1'b1, 1'b1, 3'd0, 3'd0);
    tick();
    cmp("full_alloc_ready", alloc_ready, 1'b0);
    cmp("full_occupancy", occupancy, DEPTH);
    set_idle(); cdb_valid = 4'b0001; cdb_tag = {3'd0, 3'd0, 3'd0, 3'd7}; cdb_value = {96'h0, 32'h70};
    tick();
    cmp("full_wake_occ", occupancy, DEPTH);
    cmp("full_wake_no_issue", issue_valid, 1'b0);
    set_idle(); tick();
    cmp("full_drain_valid", issue_valid, 1'b1);
    cmp("full_drain_tag", issue_rob_tag, 0);
    cmp("full_drain_a", issue_a, 32'h70);
    cmp("full_drain_ready", alloc_ready, 1'b1);
    cmp("full_drain_occ", occupancy, DEPTH - 1);
    $display("[TB] full/drain sequence done, occupancy=%0d", occupancy);

    // ---- flush together with alloc while holding an op ----
    drive_alloc(3'd2, 3'd3, 32'd1, 32'd1, 1'b1, 1'b1, 3'd0, 3'd0);
    flush = 1'b1;
    tick();
    cmp("flush_occ", occupancy, 0);
    cmp("flush_valid", issue_valid, 1'b0);
    cmp("flush_a", issue_a, 0);
    cmp("flush_tag", issue_rob_tag, 0);
    set_idle(); tick();
    cmp("flush_alloc_dropped", occupancy, 0);
    cmp("flush_still_empty", issue_valid, 1'b0);
    $display("[TB] flush sequence done");

    // ---- age order independent of slot index ----
    set_idle(); issue_ready = 1'b0; flush = 1'b1; tick();
    flush = 1'b0;
    dut_log.delete();
    drive_alloc(3'd1, 3'd1, 32'd1, 32'd1, 1'b1, 1'b1, 3'd0, 3'd0); tick();  // X -> slot0 -> output
    drive_alloc(3'd1, 3'd2, 32'd2, 32'd2, 1'b1, 1'b1, 3'd0, 3'd0); tick();  // A -> slot1
    drive_alloc(3'd1, 3'd3, 32'd3, 32'd3, 1'b1, 1'b1, 3'd0, 3'd0); tick();  // B -> slot0
    drive_alloc(3'd1, 3'd4, 32'd4, 32'd4, 1'b1, 1'b1, 3'd0, 3'd0); tick();  // T1 -> slot2
    set_idle(); issue_ready = 1'b1; tick(); tick();                          // drain X, A
    issue_ready = 1'b0;
    drive_alloc(3'd1, 3'd5, 32'd5, 32'd5, 1'b1, 1'b1, 3'd0, 3'd0); tick();  // T2 -> slot0
    drive_alloc(3'd1, 3'd6, 32'd6, 32'd6, 1'b1, 1'b1, 3'd0, 3'd0); tick();  // T3 -> slot1
    set_idle(); issue_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    cmp("age_count", dut_log.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < dut_log.size()) cmp($sformatf("age_order%0d", k), dut_log[k], k + 1);
    $display("[TB] age-order sequence done, %0d issues logged", dut_log.size());

    // ---- randomized phase against the model ----
    for (int c = 0; c < 1500; c++) begin
      alloc_valid   = ($urandom_range(0, 3) != 0);
      alloc_op      = OW'($urandom);
      alloc_rob_tag = TW'($urandom);
      alloc_vj      = $urandom;
      alloc_vk      = $urandom;
      alloc_rj      = 1'($urandom_range(0, 1));
      alloc_rk      = 1'($urandom_range(0, 1));
      alloc_qj      = TW'($urandom);
      alloc_qk      = TW'($urandom);
      cdb_valid     = NC'($urandom);
      cdb_tag       = CTW'($urandom);
      cdb_value     = {$urandom, $urandom, $urandom, $urandom};
      issue_ready   = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 99) == 0);
      tick();
    end
    set_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
